// File: rtl/cpu_control.sv
// Multicycle control unit for an eight-register accumulator-style processor.
// Fetches a 9-bit instruction from DIN and sequences mv, mvi, add, sub and nop.
module cpu_control #(
  parameter int DATA_W = 16,
  parameter int IR_LSB = 7
) (
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iRun,
  input  logic [DATA_W-1:0] iDIN,
  output logic [9:0]        oSel,
  output logic [7:0]        oRin,
  output logic              oAin,
  output logic              oGin,
  output logic              oAddSub,
  output logic              oIRin,
  output logic              oDone,
  output logic              oBusy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t     state;
  logic [8:0] ir;
  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_mv;
  logic       is_mvi;
  logic       is_sub;
  logic       is_alu;
  logic       is_nop;

  assign op     = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];
  assign is_nop = op[2];
  assign is_mv  = op == 3'b000;
  assign is_mvi = op == 3'b001;
  assign is_sub = op == 3'b011;
  assign is_alu = op[2:1] == 2'b01;

  // Only the instruction field is decoded here; the rest feeds the datapath.
  logic [DATA_W-1:0] din_rest;
  logic              unused_din;
  assign din_rest   = iDIN & ~(DATA_W'(9'h1FF) << IR_LSB);
  assign unused_din = ^din_rest;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      unique case (state)
        T0: begin
          if (iRun) begin
            ir    <= iDIN[IR_LSB+8:IR_LSB];
            state <= T1;
          end
        end
        T1:      state <= is_alu ? T2 : T0;
        T2:      state <= T3;
        T3:      state <= T0;
        default: state <= T0;
      endcase
    end
  end

  assign oBusy = state != T0;

  always_comb begin
    oSel    = '0;
    oRin    = '0;
    oAin    = 1'b0;
    oGin    = 1'b0;
    oAddSub = 1'b0;
    oIRin   = 1'b0;
    oDone   = 1'b0;
    unique case (1'b1)
      (state == T0): oIRin = iRun & iRstn;
      (state == T1 && is_mv): begin
        oSel  = 10'(1) << ry;
        oRin  = 8'(1) << rx;
        oDone = 1'b1;
      end
      (state == T1 && is_mvi): begin
        oSel  = 10'h200;
        oRin  = 8'(1) << rx;
        oDone = 1'b1;
      end
      (state == T1 && is_alu): begin
        oSel = 10'(1) << rx;
        oAin = 1'b1;
      end
      (state == T1 && is_nop): oDone = 1'b1;
      (state == T2): begin
        oSel    = 10'(1) << ry;
        oGin    = 1'b1;
        oAddSub = is_sub;
      end
      (state == T3): begin
        oSel  = 10'h100;
        oRin  = 8'(1) << rx;
        oDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of iDIN.
REQ-002 SHALL have parameter IR_LSB, default 7: LSB of the 9-bit instruction field in iDIN, so the field is iDIN[IR_LSB+8:IR_LSB].
REQ-003 SHALL have port iClk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port iRstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port iRun, input, 1: start request, sampled in state T0 only.
REQ-006 SHALL have port iDIN, input, DATA_W: instruction word; the same bus also feeds the datapath mux.
REQ-007 SHALL have port oSel, output, 10: one-hot bus-mux select; bit i (0..7) = Ri, bit 8 = G, bit 9 = DIN; all-zero = no driver.
REQ-008 SHALL have port oRin, output, 8: register-file load enables; bit i loads Ri from the bus.
REQ-009 SHALL have port oAin, output, 1: load the A operand register from the bus.
REQ-010 SHALL have port oGin, output, 1: load the G result register from the ALU.
REQ-011 SHALL have port oAddSub, output, 1: ALU op select; 0 = A+bus, 1 = A-bus.
REQ-012 SHALL have port oIRin, output, 1: instruction-fetch strobe.
REQ-013 SHALL have port oDone, output, 1: one-cycle pulse in the last step of an instruction.
REQ-014 SHALL have port oBusy, output, 1: high in any state other than T0.

Function
REQ-015 SHALL hold a 9-bit IR with format III XXX YYY, where III = opcode, XXX = Rx index and YYY = Ry index.
REQ-016 SHALL decode opcodes as: 000 mv Rx,Ry; 001 mvi Rx,#DIN; 010 add Rx,Ry; 011 sub Rx,Ry; 1xx = nop.
REQ-017 SHALL implement a 4-state FSM T0 (idle/fetch), T1, T2, T3, encoded in 2 bits.
REQ-018 SHALL behave in T0 as follows: oIRin = iRun (combinational); on a clock edge with iRun=1, IR <= iDIN field and the next state is T1; with iRun=0 it stays in T0 and IR is held.
REQ-019 SHALL execute mv in T1 as: oSel = Ry, oRin[X]=1, oDone=1, next state T0; total latency is 2 cycles including fetch.
REQ-020 SHALL execute mvi in T1 as: oSel = DIN (bit 9), oRin[X]=1, oDone=1, next state T0.
REQ-021 SHALL execute add/sub in T1 as: oSel = Rx, oAin=1, next state T2.
REQ-022 SHALL execute add/sub in T2 as: oSel = Ry, oGin=1, oAddSub = 1 for sub and 0 for add, next state T3.
REQ-023 SHALL execute add/sub in T3 as: oSel = G (bit 8), oRin[X]=1, oDone=1, next state T0; total latency is 4 cycles.
REQ-024 SHALL execute nop in T1 as: oSel = 0, all enables 0, oDone=1, next state T0.
REQ-025 SHALL drive every output not listed for the current state and opcode to 0; oSel SHALL always be one-hot or zero, never multi-hot.
REQ-026 SHALL derive all outputs combinationally from state and IR (plus iRun for oIRin only).
REQ-027 SHALL ignore iRun in T1-T3; IR SHALL NOT change outside a T0 fetch edge.
REQ-028 SHALL, when iRun is held high continuously, fetch the next instruction in the T0 following oDone with no extra idle cycle.
REQ-029 SHALL behave correctly when X = Y (e.g. add R3,R3): the sequence is unchanged and the result is 2*R3.

Reset
REQ-030 SHALL, while iRstn=0, asynchronously force state = T0 and IR = 9'b0.
REQ-031 SHALL hold, during reset, oSel=0, oRin=0, oAin=oGin=oAddSub=oDone=oBusy=0, and oIRin=0 regardless of iRun.
REQ-032 SHALL, when reset asserts mid-instruction (T1-T3), abort the instruction immediately with no oDone and no further register write.
REQ-033 SHALL resume normally after reset release: the first rising edge with iRun=1 fetches.

Verification
REQ-034 SHALL pass: reset then iRun=1 for 1 cycle with field 001_010_000 and DIN=22 -> T0 oIRin=1; T1 oSel=10'b10_0000_0000, oRin=8'b0000_0100, oDone=1; then oBusy=0.
REQ-035 SHALL pass: mv R7,R1 (000_111_001) -> T1 oSel=10'b00_0000_0010, oRin=8'b1000_0000, oDone=1.
REQ-036 SHALL pass: sub R5,R6 (011_101_110) -> T1 oSel=bit5 with oAin=1; T2 oSel=bit6 with oGin=1, oAddSub=1; T3 oSel=bit8 with oRin=bit5 and oDone=1; oDone high exactly 1 cycle.
REQ-037 SHALL pass: iRun held high over back-to-back add then mv -> oIRin=1 in the cycle immediately after the add T3 and no idle T0 cycle in between.
REQ-038 SHALL pass: iRstn pulled low during add T2 -> outputs zero immediately and state T0; no oDone.
REQ-039 SHALL pass: nop (1xx) and iRun toggling during T2 -> nop gives T1 oDone=1 with all enables 0; the toggle does not alter IR or the sequence.
